// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle control unit:
// FSM state enum, instruction field codes, datapath mux selects,
// and the packed control-word struct driven by the output decoder.
package mc_controller_pkg;

   localparam int FLAGS_W = 4;

   // NZCV bit positions inside the held flags register
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_FAULT    = 4'd10
   } state_t;

   // op field, Instr[11:10]
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_B   = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   // cmd field, Instr[8:7]; doubles as ALUControl encoding
   localparam logic [1:0] CMD_ADD = 2'b00;
   localparam logic [1:0] CMD_SUB = 2'b01;
   localparam logic [1:0] CMD_AND = 2'b10;
   localparam logic [1:0] CMD_ORR = 2'b11;

   // ARM condition codes, Instr[15:12]
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // ALUSrcB selects
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_IMM    = 2'b01;
   localparam logic [1:0] SRCB_CONST2 = 2'b10;

   // ResultSrc selects
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // ImmSrc selects
   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   // One cycle's worth of datapath control
   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] imm_src;
      logic [1:0] reg_src;
      logic [1:0] alu_control;
   } ctrl_t;

   // Store instructions read Rd as the write-data source
   function automatic logic is_store(input logic [1:0] op, input logic l_bit);
      return (op == OP_MEM) && !l_bit;
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory bundle. The controller uses the master
// modport; the datapath side (or a testbench) uses slave.
interface mc_controller_if #(
   parameter int FLAGS_W = 4
);
   logic [15:0]        Instr;
   logic [FLAGS_W-1:0] ALUFlags;
   logic               MemReady;
   logic               MemReq;
   logic               MemWrite;
   logic               PCWrite;
   logic               IRWrite;
   logic               RegWrite;
   logic               AdrSrc;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ResultSrc;
   logic [1:0]         ImmSrc;
   logic [1:0]         RegSrc;
   logic [1:0]         ALUControl;
   logic               Fault;

   modport master (
      input  Instr, ALUFlags, MemReady,
      output MemReq, MemWrite, PCWrite, IRWrite, RegWrite, AdrSrc, ALUSrcA,
             ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Fault
   );

   modport slave (
      output Instr, ALUFlags, MemReady,
      input  MemReq, MemWrite, PCWrite, IRWrite, RegWrite, AdrSrc, ALUSrcA,
             ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Fault
   );
endinterface

// File: rtl/mc_controller_cond_unit.sv
// Combinational ARM condition check: cond code x held NZCV -> pass.
// Code 1111 is treated like AL (unconditional).
module cond_unit #(
   parameter int FLAGS_W = 4
) (
   input  logic [3:0]         cond_i,
   input  logic [FLAGS_W-1:0] flags_i,
   output logic               pass_o
);
   import mc_controller_pkg::*;

   logic n, z, c, v;
   assign n = flags_i[FLAG_N];
   assign z = flags_i[FLAG_Z];
   assign c = flags_i[FLAG_C];
   assign v = flags_i[FLAG_V];

   // Decode the condition code into a pass/fail against NZCV
   always_comb begin
      pass_o = 1'b1;
      case (cond_i)
         COND_EQ: pass_o = z;
         COND_NE: pass_o = !z;
         COND_CS: pass_o = c;
         COND_CC: pass_o = !c;
         COND_MI: pass_o = n;
         COND_PL: pass_o = !n;
         COND_VS: pass_o = v;
         COND_VC: pass_o = !v;
         COND_HI: pass_o = c && !z;
         COND_LS: pass_o = !c || z;
         COND_GE: pass_o = (n == v);
         COND_LT: pass_o = (n != v);
         COND_GT: pass_o = !z && (n == v);
         COND_LE: pass_o = z || (n != v);
         default: pass_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single req/ready memory port, with conditional
// execution against a held NZCV register.
// Optional fault logic under `MC_CONTROLLER_FAULT_EN: illegal op or a
// memory wait of TIMEOUT_CYCLES consecutive cycles parks the FSM in FAULT
// until reset. Without the macro, illegal ops are NOPs and waits unbounded.
module mc_controller #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int FLAGS_W        = 4
) (
   input logic             clk,
   input logic             reset,
   mc_controller_if.master bus
);
   import mc_controller_pkg::*;

   state_t             state_q, state_d;
   logic [FLAGS_W-1:0] flags_q, flags_d;
   logic               cond_pass;
   ctrl_t              ctrl;

   logic [3:0] cond;
   logic [1:0] op;
   logic       imm_f;
   logic [1:0] cmd;
   logic       sl_f;
   logic       unused_instr;

   assign cond         = bus.Instr[15:12];
   assign op           = bus.Instr[11:10];
   assign imm_f        = bus.Instr[9];
   assign cmd          = bus.Instr[8:7];
   assign sl_f         = bus.Instr[6];
   assign unused_instr = ^bus.Instr[5:0];

   cond_unit #(.FLAGS_W(FLAGS_W)) u_cond (
      .cond_i  (cond),
      .flags_i (flags_q),
      .pass_o  (cond_pass)
   );

`ifdef MC_CONTROLLER_FAULT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic             mem_wait;
   logic             timeout;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE)) && !bus.MemReady;
   assign timeout  = mem_wait && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count consecutive stalled request cycles; any non-stall clears it
   always_comb begin
      wait_cnt_d = '0;
      if (mem_wait) wait_cnt_d = wait_cnt_q + 1'b1;
   end

   // Wait counter register
   always_ff @(posedge clk) begin
      if (reset) wait_cnt_q <= '0;
      else       wait_cnt_q <= wait_cnt_d;
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

   // Flags change only on the execute edge of an S-suffixed DP instruction
   always_comb begin
      flags_d = flags_q;
      if (((state_q == S_EXECR) || (state_q == S_EXECI)) && sl_f)
         flags_d = bus.ALUFlags;
   end

   // Held NZCV register
   always_ff @(posedge clk) begin
      if (reset) flags_q <= '0;
      else       flags_q <= flags_d;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
         S_DECODE: begin
            if (!cond_pass) begin
               state_d = S_FETCH;
            end else begin
               case (op)
                  OP_DP:   state_d = imm_f ? S_EXECI : S_EXECR;
                  OP_MEM:  state_d = S_MEMADR;
                  OP_B:    state_d = S_BRANCH;
`ifdef MC_CONTROLLER_FAULT_EN
                  default: state_d = S_FAULT;
`else
                  default: state_d = S_FETCH;
`endif
               endcase
            end
         end
         S_EXECR,
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_MEMADR:   state_d = sl_f ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
`ifdef MC_CONTROLLER_FAULT_EN
         S_FAULT:    state_d = S_FAULT;
`endif
         default:    state_d = S_FETCH;
      endcase
`ifdef MC_CONTROLLER_FAULT_EN
      if (timeout) state_d = S_FAULT;
`endif
   end

   // FSM output decode; everything is forced low while reset is held so a
   // reset during a memory access drops the request and blocks all writes
   always_comb begin
      ctrl = '0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               ctrl.mem_req     = 1'b1;
               ctrl.alu_src_a   = 1'b1;
               ctrl.alu_src_b   = SRCB_CONST2;
               ctrl.alu_control = CMD_ADD;
               ctrl.result_src  = RES_ALU;
               ctrl.pc_write    = bus.MemReady;
               ctrl.ir_write    = bus.MemReady;
            end
            S_EXECR: begin
               ctrl.alu_control = cmd;
               ctrl.alu_src_b   = SRCB_REG;
            end
            S_EXECI: begin
               ctrl.alu_control = cmd;
               ctrl.alu_src_b   = SRCB_IMM;
               ctrl.imm_src     = IMM_DP;
            end
            S_ALUWB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.result_src = RES_ALUOUT;
            end
            S_MEMADR: begin
               ctrl.alu_control = CMD_ADD;
               ctrl.alu_src_b   = SRCB_IMM;
               ctrl.imm_src     = IMM_MEM;
               ctrl.reg_src[1]  = is_store(op, sl_f);
            end
            S_MEMREAD: begin
               ctrl.mem_req = 1'b1;
               ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.result_src = RES_DATA;
            end
            S_MEMWRITE: begin
               ctrl.mem_req    = 1'b1;
               ctrl.mem_write  = 1'b1;
               ctrl.adr_src    = 1'b1;
               ctrl.reg_src[1] = 1'b1;
            end
            S_BRANCH: begin
               ctrl.alu_src_b  = SRCB_IMM;
               ctrl.imm_src    = IMM_BR;
               ctrl.result_src = RES_ALU;
               ctrl.pc_write   = 1'b1;
               ctrl.reg_src[0] = 1'b1;
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign bus.MemReq     = ctrl.mem_req;
   assign bus.MemWrite   = ctrl.mem_write;
   assign bus.PCWrite    = ctrl.pc_write;
   assign bus.IRWrite    = ctrl.ir_write;
   assign bus.RegWrite   = ctrl.reg_write;
   assign bus.AdrSrc     = ctrl.adr_src;
   assign bus.ALUSrcA    = ctrl.alu_src_a;
   assign bus.ALUSrcB    = ctrl.alu_src_b;
   assign bus.ResultSrc  = ctrl.result_src;
   assign bus.ImmSrc     = ctrl.imm_src;
   assign bus.RegSrc     = ctrl.reg_src;
   assign bus.ALUControl = ctrl.alu_control;

`ifdef MC_CONTROLLER_FAULT_EN
   assign bus.Fault = !reset && (state_q == S_FAULT);
`else
   assign bus.Fault = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus a random
// instruction stream checked against an instruction-level reference model.
module tb_mc_controller;
   import mc_controller_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mc_controller_if #(.FLAGS_W(4)) bus();

   mc_controller #(.TIMEOUT_CYCLES(16), .FLAGS_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [3:0] mflags;

   // Per-instruction observation / expectation summary
   typedef struct {
      int         cycles;
      int         pcw;
      int         irw;
      int         rgw;
      int         rgw_cyc;
      logic [1:0] rgw_res;
      int         memreq;
      int         memwr;
      int         memwr_cyc;
      int         memwr_bad;
      logic [1:0] aluc_or;
      logic [1:0] imm_or;
      logic [1:0] regsrc_or;
      int         fault;
      int         timeout;
   } obs_t;

   function automatic logic [16:0] outs();
      return {bus.MemReq, bus.MemWrite, bus.PCWrite, bus.IRWrite, bus.RegWrite,
              bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
              bus.RegSrc, bus.ALUControl};
   endfunction

   function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   // Instruction-level model: latency, write counts and selects
   function automatic obs_t model(input logic [15:0] instr, input logic [3:0] fl,
                                  input int fw, input int mw);
      obs_t e;
      bit pass, dp, mem, br, ld;
      e = '{default: 0};
      pass = cond_holds(instr[15:12], fl);
      dp   = pass && (instr[11:10] == 2'b00);
      mem  = pass && (instr[11:10] == 2'b01);
      br   = pass && (instr[11:10] == 2'b10);
      ld   = instr[6];
      e.cycles = fw + 2;
      if (dp)  e.cycles = fw + 4;
      if (mem) e.cycles = fw + mw + (ld ? 5 : 4);
      if (br)  e.cycles = fw + 3;
      e.pcw     = br ? 2 : 1;
      e.irw     = 1;
      e.rgw     = (dp || (mem && ld)) ? 1 : 0;
      e.rgw_cyc = e.rgw ? e.cycles : 0;
      e.rgw_res = dp ? 2'b00 : (e.rgw ? 2'b01 : 2'b00);
      e.memreq  = fw + 1 + (mem ? mw + 1 : 0);
      e.memwr   = (mem && !ld) ? mw + 1 : 0;
      e.memwr_cyc = e.memwr ? e.cycles : 0;
      e.aluc_or = dp ? instr[8:7] : 2'b00;
      e.imm_or  = mem ? 2'b01 : (br ? 2'b10 : 2'b00);
      e.regsrc_or = br ? 2'b01 : ((mem && !ld) ? 2'b10 : 2'b00);
      return e;
   endfunction

   function automatic logic [3:0] model_flags(input logic [15:0] instr, input logic [3:0] fl,
                                              input logic [3:0] aluf);
      if (cond_holds(instr[15:12], fl) && instr[11:10] == 2'b00 && instr[6]) return aluf;
      return fl;
   endfunction

   // Runs one instruction from its FETCH cycle up to (not into) the next
   // FETCH. Entry/exit point: just after a rising edge.
   task automatic run_instr(input logic [15:0] instr, input logic [3:0] aluf,
                            input int fw, input int mw, output obs_t o);
      int fl, ml;
      bit fetch_done;
      fl = fw; ml = mw; fetch_done = 0;
      o = '{default: 0};
      o.timeout = 1;
      bus.Instr = instr;
      bus.ALUFlags = aluf;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (fetch_done && bus.MemReq && !bus.AdrSrc) begin
            o.timeout = 0;
            break;
         end
         if (bus.MemReq && !bus.AdrSrc) begin
            bus.MemReady = (fl == 0);
            if (fl > 0) fl--;
         end else if (bus.MemReq) begin
            bus.MemReady = (ml == 0);
            if (ml > 0) ml--;
         end else begin
            bus.MemReady = 1'($urandom_range(0, 1));
         end
         #1;
         o.cycles++;
         if (bus.PCWrite) o.pcw++;
         if (bus.IRWrite) o.irw++;
         if (bus.RegWrite) begin
            o.rgw++; o.rgw_cyc = o.cycles; o.rgw_res = bus.ResultSrc;
         end
         if (bus.MemReq) o.memreq++;
         if (bus.MemWrite) begin
            o.memwr++; o.memwr_cyc = o.cycles;
            if (!(bus.MemReq && bus.AdrSrc)) o.memwr_bad++;
         end
         o.aluc_or   |= bus.ALUControl;
         o.imm_or    |= bus.ImmSrc;
         o.regsrc_or |= bus.RegSrc;
         if (bus.Fault) o.fault++;
         if (bus.MemReq && !bus.AdrSrc && bus.MemReady) fetch_done = 1;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      mflags = 4'b0000;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.MemReady = 1'b1; bus.Instr = 16'hE040; bus.ALUFlags = 4'b0000;
      #2;
      checks++;
      if (outs() !== 17'h0 || bus.Fault !== 1'b0) begin
         errors++; $display("FAIL reset_outs_pre_edge: got %h expected 0", outs());
      end
      @(posedge clk); #1;
      checks++;
      if (outs() !== 17'h0 || bus.Fault !== 1'b0) begin
         errors++; $display("FAIL reset_outs: got %h expected 0", outs());
      end
      reset = 1'b0; mflags = 4'b0000;
      #1;
      checks++;
      if (bus.MemReq !== 1'b1 || bus.AdrSrc !== 1'b0) begin
         errors++; $display("FAIL reset_first_fetch: got MemReq=%b AdrSrc=%b expected 1 0", bus.MemReq, bus.AdrSrc);
      end
   endtask

   task automatic test_dp();
      obs_t o;
      run_instr(16'hE040, 4'b0100, 0, 0, o);     // ADDS AL, reg operand
      checks++;
      if (o.cycles !== 4) begin errors++; $display("FAIL adds_cycles: got %0d expected 4", o.cycles); end
      checks++;
      if (o.rgw !== 1 || o.rgw_cyc !== 4 || o.rgw_res !== 2'b00) begin
         errors++; $display("FAIL adds_regwrite: got n=%0d cyc=%0d res=%b expected 1 4 00", o.rgw, o.rgw_cyc, o.rgw_res);
      end
      mflags = 4'b0100;
      run_instr(16'hE2C0, 4'b0010, 1, 0, o);     // SUBS AL, immediate, one fetch wait
      checks++;
      if (o.cycles !== 5 || o.aluc_or !== 2'b01) begin
         errors++; $display("FAIL subs_imm: got cycles=%0d aluc=%b expected 5 01", o.cycles, o.aluc_or);
      end
      mflags = 4'b0010;
      run_instr(16'hE180, 4'b0100, 0, 0, o);     // ORR AL, no S: flags untouched
      checks++;
      if (o.aluc_or !== 2'b11 || o.pcw !== 1) begin
         errors++; $display("FAIL orr_nos: got aluc=%b pcw=%0d expected 11 1", o.aluc_or, o.pcw);
      end
   endtask

   task automatic test_branch();
      obs_t o;
      run_instr(16'hE040, 4'b0000, 0, 0, o);     // clear Z
      mflags = 4'b0000;
      run_instr(16'h0800, 4'b1111, 0, 0, o);     // BEQ, Z=0: not taken
      checks++;
      if (o.cycles !== 2 || o.pcw !== 1) begin
         errors++; $display("FAIL beq_fail: got cycles=%0d pcw=%0d expected 2 1", o.cycles, o.pcw);
      end
      run_instr(16'hE040, 4'b0100, 0, 0, o);     // set Z
      mflags = 4'b0100;
      run_instr(16'h0800, 4'b0000, 0, 0, o);     // BEQ, Z=1: taken
      checks++;
      if (o.cycles !== 3 || o.pcw !== 2 || o.regsrc_or !== 2'b01 || o.imm_or !== 2'b10) begin
         errors++; $display("FAIL beq_taken: got cycles=%0d pcw=%0d regsrc=%b imm=%b expected 3 2 01 10",
                            o.cycles, o.pcw, o.regsrc_or, o.imm_or);
      end
   endtask

   task automatic test_ldr_wait();
      obs_t o;
      run_instr(16'hE640, 4'b0000, 0, 3, o);     // LDR AL, 3 wait cycles
      checks++;
      if (o.cycles !== 8) begin errors++; $display("FAIL ldr_cycles: got %0d expected 8", o.cycles); end
      checks++;
      if (o.memreq !== 5) begin errors++; $display("FAIL ldr_memreq_held: got %0d expected 5", o.memreq); end
      checks++;
      if (o.rgw !== 1 || o.rgw_res !== 2'b01 || o.rgw_cyc !== 8) begin
         errors++; $display("FAIL ldr_regwrite: got n=%0d res=%b cyc=%0d expected 1 01 8", o.rgw, o.rgw_res, o.rgw_cyc);
      end
   endtask

   task automatic test_str();
      obs_t o;
      run_instr(16'hE600, 4'b0000, 0, 0, o);     // STR AL
      checks++;
      if (o.cycles !== 4 || o.memwr !== 1 || o.memwr_cyc !== 4 || o.memwr_bad !== 0) begin
         errors++; $display("FAIL str_write: got cycles=%0d n=%0d cyc=%0d bad=%0d expected 4 1 4 0",
                            o.cycles, o.memwr, o.memwr_cyc, o.memwr_bad);
      end
      checks++;
      if (o.rgw !== 0 || o.regsrc_or !== 2'b10) begin
         errors++; $display("FAIL str_regs: got rgw=%0d regsrc=%b expected 0 10", o.rgw, o.regsrc_or);
      end
   endtask

   task automatic test_reset_mid_access();
      obs_t o;
      run_instr(16'hE040, 4'b0100, 0, 0, o);     // Z=1 before the reset
      mflags = 4'b0100;
      bus.Instr = 16'hE640;
      for (int i = 0; i < 3; i++) begin
         bus.MemReady = 1'b1;
         @(posedge clk); #1;
      end
      bus.MemReady = 1'b0;
      #1;
      checks++;
      if (bus.MemReq !== 1'b1 || bus.AdrSrc !== 1'b1) begin
         errors++; $display("FAIL midreset_in_memread: got MemReq=%b AdrSrc=%b expected 1 1", bus.MemReq, bus.AdrSrc);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      checks++;
      if (outs() !== 17'h0) begin errors++; $display("FAIL midreset_outs: got %h expected 0", outs()); end
      @(posedge clk); #1;
      reset = 1'b0; mflags = 4'b0000;
      #1;
      checks++;
      if (bus.MemReq !== 1'b1 || bus.AdrSrc !== 1'b0 || bus.RegWrite !== 1'b0) begin
         errors++; $display("FAIL midreset_fetch: got MemReq=%b AdrSrc=%b RegWrite=%b expected 1 0 0",
                            bus.MemReq, bus.AdrSrc, bus.RegWrite);
      end
      run_instr(16'h0800, 4'b0000, 0, 0, o);     // BEQ must now fail: flags cleared
      checks++;
      if (o.cycles !== 2) begin errors++; $display("FAIL midreset_flags: got cycles=%0d expected 2", o.cycles); end
   endtask

   task automatic test_illegal();
`ifdef MC_CONTROLLER_FAULT_EN
      bus.Instr = 16'hEC00;
      for (int i = 0; i < 2; i++) begin
         bus.MemReady = 1'b1;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
         bus.MemReady = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (bus.Fault !== 1'b1 || outs() !== 17'h0) begin
            errors++; $display("FAIL illegal_fault: got Fault=%b outs=%h expected 1 0", bus.Fault, outs());
         end
         @(posedge clk); #1;
      end
      do_reset();
      checks++;
      if (bus.Fault !== 1'b0) begin errors++; $display("FAIL fault_cleared: got %b expected 0", bus.Fault); end
`else
      obs_t o;
      run_instr(16'hEC00, 4'b1111, 0, 0, o);
      checks++;
      if (o.cycles !== 2 || o.pcw !== 1 || o.rgw !== 0 || o.fault !== 0) begin
         errors++; $display("FAIL illegal_nop: got cycles=%0d pcw=%0d rgw=%0d fault=%0d expected 2 1 0 0",
                            o.cycles, o.pcw, o.rgw, o.fault);
      end
`endif
   endtask

   task automatic test_timeout();
      obs_t o;
      run_instr(16'hE040, 4'b0000, 15, 0, o);    // 15 waits: just under the limit
      checks++;
      if (o.cycles !== 19 || o.fault !== 0 || o.timeout !== 0) begin
         errors++; $display("FAIL wait15: got cycles=%0d fault=%0d expected 19 0", o.cycles, o.fault);
      end
      mflags = 4'b0000;
`ifdef MC_CONTROLLER_FAULT_EN
      for (int i = 1; i <= 16; i++) begin
         bus.MemReady = 1'b0;
         #1;
         if (i == 16) begin
            checks++;
            if (bus.Fault !== 1'b0 || bus.MemReq !== 1'b1) begin
               errors++; $display("FAIL timeout_early: got Fault=%b MemReq=%b expected 0 1", bus.Fault, bus.MemReq);
            end
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
         bus.MemReady = 1'b1;
         #1;
         checks++;
         if (bus.Fault !== 1'b1 || outs() !== 17'h0) begin
            errors++; $display("FAIL timeout_fault: got Fault=%b outs=%h expected 1 0", bus.Fault, outs());
         end
         @(posedge clk); #1;
      end
      do_reset();
`endif
   endtask

   task automatic test_back_to_back();
      obs_t o, e;
      logic [15:0] instr;
      logic [3:0]  aluf;
      int fw, mw;
      for (int n = 0; n < 50; n++) begin
         instr[15:12] = ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom_range(0, 14));
`ifdef MC_CONTROLLER_FAULT_EN
         instr[11:10] = 2'($urandom_range(0, 2));
`else
         instr[11:10] = 2'($urandom_range(0, 3));
`endif
         instr[9:0] = 10'($urandom);
         aluf = 4'($urandom);
         fw = $urandom_range(0, 3);
         mw = $urandom_range(0, 3);
         e = model(instr, mflags, fw, mw);
         run_instr(instr, aluf, fw, mw, o);
         checks++;
         if (o.timeout !== 0 || o.cycles !== e.cycles) begin
            errors++; $display("FAIL rnd_cycles instr=%h: got %0d expected %0d", instr, o.cycles, e.cycles);
         end
         checks++;
         if (o.pcw !== e.pcw || o.irw !== e.irw) begin
            errors++; $display("FAIL rnd_pc_ir instr=%h: got %0d/%0d expected %0d/%0d", instr, o.pcw, o.irw, e.pcw, e.irw);
         end
         checks++;
         if (o.rgw !== e.rgw || o.rgw_cyc !== e.rgw_cyc || o.rgw_res !== e.rgw_res) begin
            errors++; $display("FAIL rnd_regwrite instr=%h: got %0d@%0d/%b expected %0d@%0d/%b",
                               instr, o.rgw, o.rgw_cyc, o.rgw_res, e.rgw, e.rgw_cyc, e.rgw_res);
         end
         checks++;
         if (o.memreq !== e.memreq || o.memwr !== e.memwr || o.memwr_cyc !== e.memwr_cyc || o.memwr_bad !== 0) begin
            errors++; $display("FAIL rnd_mem instr=%h: got req=%0d wr=%0d@%0d bad=%0d expected %0d %0d@%0d 0",
                               instr, o.memreq, o.memwr, o.memwr_cyc, o.memwr_bad, e.memreq, e.memwr, e.memwr_cyc);
         end
         checks++;
         if (o.aluc_or !== e.aluc_or || o.imm_or !== e.imm_or || o.regsrc_or !== e.regsrc_or || o.fault !== 0) begin
            errors++; $display("FAIL rnd_selects instr=%h: got alu=%b imm=%b rs=%b f=%0d expected %b %b %b 0",
                               instr, o.aluc_or, o.imm_or, o.regsrc_or, o.fault, e.aluc_or, e.imm_or, e.regsrc_or);
         end
         mflags = model_flags(instr, mflags, aluf);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_dp();
      test_branch();
      test_ldr_wait();
      test_str();
      test_reset_mid_access();
      test_illegal();
      test_timeout();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised multicycle control unit for the 16-bit-instruction / 32-bit-data CPU, replacing the single-cycle controller so that the datapath shares one ALU and one memory port across cycles. A state machine sequences fetch, decode, execute, memory and writeback, with a req/ready memory handshake for variable-latency memory, ARM-style conditional execution against a held NZCV register, and an optional fault state. It sits beside the datapath inside the CPU top and drives every datapath mux, enable and memory control.

## Interface
- TIMEOUT_CYCLES, 16: memory-wait limit before fault (only with fault logic compiled in; ≥1).
- FLAGS_W, 4: NZCV width; fixed order N,Z,C,V = [3:0].
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  16  instruction-register contents from datapath.
- ALUFlags  in  FLAGS_W  live ALU flags.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  write qualifier, valid only with MemReq.
- PCWrite, IRWrite, RegWrite, AdrSrc, ALUSrcA  out  1 each.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  out  2 each.
- Fault  out  1  sticky fault indicator.

## Operation
- Fields: cond=Instr[15:12] (ARM codes, 1110=AL), op=Instr[11:10] (00 DP, 01 MEM, 10 B, 11 illegal), I=Instr[9], cmd=Instr[8:7] (00 ADD, 01 SUB, 10 AND, 11 ORR), S/L=Instr[6].
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, FAULT.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1 (PC), ALUSrcB=10 (const 2), ALUControl=ADD, ResultSrc=10; PCWrite=IRWrite=MemReady; leave only when MemReady=1 → DECODE.
- DECODE: cond evaluated on held flags. Fail → FETCH (no side effects). Pass: DP → EXECR/EXECI per I; MEM → MEMADR; B → BRANCH; illegal → FAULT (with macro) or FETCH.
- EXECR/EXECI: ALUControl=cmd, ALUSrcA=0, ALUSrcB=00 reg / 01 imm; flags register loads ALUFlags if S=1 → ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00 → FETCH.
- MEMADR: ALUControl=ADD, ALUSrcB=01 → MEMREAD if L else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1; on MemReady → MEMWB. MEMWB: RegWrite=1, ResultSrc=01 → FETCH.
- MEMWRITE: MemReq=MemWrite=1, AdrSrc=1; on MemReady → FETCH.
- BRANCH: ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=1 → FETCH.
- ImmSrc: 00 DP, 01 MEM, 10 B; RegSrc[0]=1 in BRANCH, RegSrc[1]=1 for STR (read Rd as store data).
- All unlisted outputs 0 in each state.

## Timing
- Reset: state=FETCH, flags=0, Fault=0, every output 0 in the reset cycle; first MemReq the cycle after reset deasserts.
- Zero-wait latencies: DP 4, LDR 5, STR 4, B 3, cond-fail 2 cycles; each MemReady-low cycle adds one.
- Handshake: MemReq and address controls held stable until MemReady sampled high; MemReady ignored when MemReq=0.
- Reset mid-access: returns to FETCH immediately; outstanding request dropped, no PC/IR/reg write.
- Flags captured only at the EXECR/EXECI edge; never changed by MEM or B.
- Exactly one PCWrite per instruction except branches (two: fetch, BRANCH).

## Configuration
- MC_CONTROLLER_FAULT_EN defined: illegal op → FAULT; a wait counter counts consecutive MemReq&&!MemReady cycles, reaching TIMEOUT_CYCLES → FAULT. FAULT: all outputs 0, Fault=1, exits only on reset.
- Undefined: no counter, no FAULT state; illegal op executes as NOP (DECODE → FETCH); Fault tied 0; waits unbounded.

## Structure
- Package mc_controller_pkg: state enum, op/cond/cmd encodings, ALUSrcB/ResultSrc/ImmSrc constants, FLAGS_W.
- Sub-module cond_unit: combinational cond×NZCV → pass.
- Next-state + output decode in mc_controller; flags register and wait counter local.

## Test plan
- Reset, then 0xE040 (ADDS AL) with MemReady=1 and ALUFlags=0100 → FETCH,DECODE,EXECR,ALUWB; RegWrite only in cycle 4; flags=0100.
- 0xE640 (LDR AL), MemReady low 3 cycles in MEMREAD → 8 cycles total, MemReq held, RegWrite with ResultSrc=01 once.
- 0x0800 (BEQ) with flags Z=0 → 2 cycles, PCWrite only in FETCH; with Z=1 → 3 cycles, PCWrite in BRANCH.
- 0xE600 (STR AL) → MemReq=MemWrite=1 with AdrSrc=1 in cycle 4, RegWrite never.
- Reset asserted during MEMREAD wait → next cycle FETCH, outputs 0, flags 0.
- Macro on: MemReady stuck low 16 cycles in FETCH → Fault=1 and held; op=11 → FAULT. Macro off: op=11 → 2-cycle NOP, Fault=0.
